// File: rtl/alu_md_pkg.sv
// Shared definitions for the ALU/multiply-divide block: opcode encodings,
// FSM state type and opcode-class helpers.
package alu_md_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  // True when operand A is interpreted as signed (B is too, except for MULHSU).
  function automatic logic is_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: logic/arith/shift/compare ops plus the divide
// special cases (divide by zero, signed overflow) that need no iteration.
module alu_comb
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            single_cycle
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [SHW-1:0] shamt;
  logic           div_zero;
  logic           div_ovf;

  assign shamt        = src_b[SHW-1:0];
  assign div_zero     = (src_b == '0);
  assign div_ovf      = is_signed(alu_op) && (src_a == MIN_NEG) && (src_b == '1);
  assign single_cycle = !is_muldiv(alu_op) || (is_div(alu_op) && (div_zero || div_ovf));

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADD:  result = src_a + src_b;
      OP_SUB:  result = src_a - src_b;
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_XOR:  result = src_a ^ src_b;
      OP_SLL:  result = src_a << shamt;
      OP_SRL:  result = src_a >> shamt;
      OP_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      // Overflow case returns src_a for the quotient and 0 for the remainder.
      OP_DIV, OP_DIVU: result = div_zero ? '1 : src_a;
      OP_REM, OP_REMU: result = div_zero ? src_a : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_md.sv
// ALU with iterative multiply/divide: single-cycle ops go straight to DONE,
// MUL*/DIV*/REM* run a one-bit-per-cycle engine on operand magnitudes.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag
);

  state_t          state_reg;
  logic [4:0]      op_reg;
  logic [XLEN-1:0] opnd_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic            neg_reg;
  logic [SHW-1:0]  cnt_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;

  logic [XLEN-1:0] comb_result;
  logic            comb_single;

  alu_comb #(.XLEN(XLEN), .SHW(SHW)) u_comb (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_op      (alu_op),
    .result      (comb_result),
    .single_cycle(comb_single)
  );

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign a_neg = is_signed(alu_op) && src_a[XLEN-1];
  assign b_neg = is_signed(alu_op) && (alu_op != OP_MULHSU) && src_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   hi_next;
  logic [XLEN-1:0]   lo_next;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_adj;
  logic [XLEN-1:0]   fin_result;

  // Multiply: shift-add with multiplier in lo. Divide: restoring, dividend
  // shifts out of lo while quotient bits shift in; hi holds the remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_trial = {hi_reg, lo_reg[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, opnd_reg});
    if (is_div(op_reg)) begin
      hi_next = div_ge ? (div_trial[XLEN-1:0] - opnd_reg) : div_trial[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], div_ge};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
    prod     = {hi_next, lo_next};
    prod_adj = neg_reg ? -prod : prod;
    case (op_reg)
      OP_MUL:          fin_result = prod_adj[XLEN-1:0];
      OP_DIV, OP_DIVU: fin_result = neg_reg ? -lo_next : lo_next;
      OP_REM, OP_REMU: fin_result = neg_reg ? -hi_next : hi_next;
      default:         fin_result = prod_adj[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          op_reg <= alu_op;
          if (comb_single) begin
            result_reg <= comb_result;
            zero_reg   <= (comb_result == '0);
            state_reg  <= DONE;
          end else begin
            hi_reg    <= '0;
            lo_reg    <= is_div(alu_op) ? a_mag : b_mag;
            opnd_reg  <= is_div(alu_op) ? b_mag : a_mag;
            // Remainder follows the dividend's sign; everything else the XOR.
            neg_reg   <= (alu_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            cnt_reg   <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + SHW'(1);
          if (cnt_reg == SHW'(XLEN-1)) begin
            result_reg <= fin_result;
            zero_reg   <= (fin_result == '0);
            state_reg  <= DONE;
          end
        end
        DONE: if (out_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign alu_result = result_reg;
  assign zero_flag  = zero_reg;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: XLEN=32 and XLEN=64 instances, directed
// vectors pushed on accept, a monitor pops and checks on each out_valid rise.
module tb_alu_md;
  import alu_md_pkg::*;

  typedef struct {
    int          dut;
    logic [4:0]  op;
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0]       zero_flag;
  logic [1:0][63:0] result;
  logic [63:0]      src_a;
  logic [63:0]      src_b;
  logic [4:0]       alu_op;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [1:0] ov_prev = '0;
  logic [1:0] busy_bad = '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int W = 32 << gi;
    logic [W-1:0] res_w;
    alu_md #(.XLEN(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .src_a     (src_a[W-1:0]),
      .src_b     (src_b[W-1:0]),
      .alu_op    (alu_op),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .alu_result(res_w),
      .zero_flag (zero_flag[gi])
    );
    assign result[gi] = 64'(res_w);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  // Monitor: checks result, zero flag, latency and that in_ready stayed low while busy.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sb_q.size() > 0 && sb_q[0].dut == d && !out_valid[d] && in_ready[d])
        busy_bad[d] = 1'b1;
      if (out_valid[d] && !ov_prev[d]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: dut%0d raised out_valid with no pending request", d);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("dut_id op%0d", mon_e.op), 64'(d), 64'(mon_e.dut));
          chk($sformatf("result dut%0d op%0d", d, mon_e.op), result[d], mon_e.res);
          chk($sformatf("zero_flag dut%0d op%0d", d, mon_e.op), 64'(zero_flag[d]),
              64'(mon_e.res == 64'd0));
          chk($sformatf("latency dut%0d op%0d", d, mon_e.op), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          chk($sformatf("ready_low dut%0d op%0d", d, mon_e.op), 64'(busy_bad[d]), 64'd0);
          busy_bad[d] = 1'b0;
          $display("txn dut%0d op=%0d res=%h zero=%0b lat=%0d", d, mon_e.op, result[d],
                   zero_flag[d], cyc - mon_e.acc);
        end
      end
      ov_prev[d] = out_valid[d];
    end
  end

  task automatic issue(input int d, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] r, input int lat);
    exp_t e;
    int   t;
    alu_op = op;
    src_a = a;
    src_b = b;
    in_valid[d] = 1'b1;
    t = 0;
    while (!in_ready[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("accept", 64'(in_ready[d]), 64'd1);
    e.dut = d;
    e.op = op;
    e.res = r;
    e.lat = lat;
    e.acc = cyc;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the captured request must be unaffected.
    in_valid[d] = 1'b0;
    src_a = ~a;
    src_b = ~b;
    alu_op = op ^ 5'h15;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic reset_mid(input int d, input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b);
    drain();
    issue(d, op, a, b, 64'd0, 0);
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
    chk("rst_result", result[d], 64'd0);
    chk("rst_zero", 64'(zero_flag[d]), 64'd0);
    chk("rst_in_ready", 64'(in_ready[d]), 64'd1);
    sb_q.delete();
    busy_bad = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready[d]), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = 2'b11;
    src_a = '0;
    src_b = '0;
    alu_op = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 64'(in_ready[d]), 64'd1);
      chk("reset_out_valid", 64'(out_valid[d]), 64'd0);
      chk("reset_result", result[d], 64'd0);
      chk("reset_zero", 64'(zero_flag[d]), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("first_cycle_in_ready", 64'(in_ready), 64'd3);

    // XLEN=32 directed vectors
    issue(0, OP_ADD,    64'h7FFFFFFF, 64'h1,        64'h80000000, 1);
    issue(0, OP_SUB,    64'h5,        64'h7,        64'hFFFFFFFE, 1);
    issue(0, OP_AND,    64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 1);
    issue(0, OP_OR,     64'h0F000000, 64'h000000F0, 64'h0F0000F0, 1);
    issue(0, OP_XOR,    64'hFFFF0000, 64'hFF00FF00, 64'h00FFFF00, 1);
    issue(0, OP_SLL,    64'h1,        64'h21,       64'h2,        1);
    issue(0, OP_SRL,    64'h80000000, 64'h24,       64'h08000000, 1);
    issue(0, OP_SRA,    64'h80000000, 64'h24,       64'hF8000000, 1);
    issue(0, OP_SLTU,   64'h1,        64'hFFFFFFFF, 64'h1,        1);
    issue(0, OP_SLT,    64'h1,        64'hFFFFFFFF, 64'h0,        1);
    issue(0, 5'h12,     64'h5,        64'h5,        64'h0,        1);
    issue(0, 5'h1F,     64'h3,        64'h4,        64'h0,        1);
    issue(0, OP_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0,        33);
    issue(0, OP_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
    issue(0, OP_MUL,    64'h7,        64'h6,        64'h2A,       33);
    issue(0, OP_MUL,    64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1,        33);
    issue(0, OP_MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 33);
    issue(0, OP_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33);
    issue(0, OP_REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33);
    issue(0, OP_DIV,    64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 33);
    issue(0, OP_REM,    64'h7,        64'hFFFFFFFE, 64'h1,        33);
    issue(0, OP_DIVU,   64'h64,       64'h7,        64'hE,        33);
    issue(0, OP_REMU,   64'h64,       64'h7,        64'h2,        33);
    issue(0, OP_DIVU,   64'h1234,     64'h0,        64'hFFFFFFFF, 1);
    issue(0, OP_REMU,   64'h1234,     64'h0,        64'h1234,     1);
    issue(0, OP_DIV,    64'h5,        64'h0,        64'hFFFFFFFF, 1);
    issue(0, OP_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
    issue(0, OP_REM,    64'h80000000, 64'hFFFFFFFF, 64'h0,        1);
    drain();

    // Back-pressure: DONE held while out_ready is low, pending request ignored
    out_ready[0] = 1'b0;
    issue(0, OP_ADD, 64'h3, 64'h4, 64'h7, 1);
    alu_op = OP_XOR;
    src_a = 64'hF0;
    src_b = 64'h0F;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid[0]), 64'd1);
      chk("stall_in_ready", 64'(in_ready[0]), 64'd0);
      chk("stall_result", result[0], 64'h7);
    end
    out_ready[0] = 1'b1;
    issue(0, OP_XOR, 64'hF0, 64'h0F, 64'hFF, 1);

    reset_mid(0, OP_DIVU, 64'h64, 64'h7);
    issue(0, OP_DIVU, 64'h64, 64'h7, 64'hE, 33);
    drain();

    // XLEN=64
    issue(1, OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65);
    issue(1, OP_DIVU,  64'h3E8,              64'hA,                64'h64,               65);
    issue(1, OP_DIV,   64'hFFFFFFFFFFFFFFF9, 64'h2,                64'hFFFFFFFFFFFFFFFD, 65);
    issue(1, OP_SRA,   64'h8000000000000000, 64'h44,               64'hF800000000000000, 1);
    issue(1, OP_SUB,   64'h5,                64'h5,                64'h0,                1);
    reset_mid(1, OP_DIVU, 64'h3E8, 64'hA);
    issue(1, OP_DIVU,  64'h3E8,              64'hA,                64'h64,               65);
    issue(1, OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64 only.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present on src_a/src_b/alu_op.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 src_a  input  XLEN  operand A.
REQ-008 src_b  input  XLEN  operand B.
REQ-009 alu_op  input  5  operation select, encodings per REQ-014.
REQ-010 out_valid  output  1  result/zero_flag valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 alu_result  output  XLEN  registered result.
REQ-013 zero_flag  output  1  registered; 1 iff alu_result == 0.

Function
REQ-014 Encodings SHALL be: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT, 01001 SLTU, 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU, 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU; all others yield result 0 with single-cycle latency.
REQ-015 Shifts SHALL use src_b[SHW-1:0] only; SRA sign-fills from src_a[XLEN-1].
REQ-016 SLT signed, SLTU unsigned compare; result 1 or 0 zero-extended to XLEN.
REQ-017 ADD/SUB/MUL SHALL wrap modulo 2^XLEN; MULH* return upper XLEN bits of the 2*XLEN product with RISC-V M signedness.
REQ-018 Request accepted on rising edge where in_valid && in_ready; operands and op captured, later input changes ignored.
REQ-019 FSM states IDLE, CALC, DONE; in_ready = (state == IDLE) only.
REQ-020 IDLE->DONE on accept for ops 00000-01001, undefined ops, and division fast paths (REQ-023/024): out_valid rises 1 cycle after accept.
REQ-021 IDLE->CALC on accept for MUL*/DIV*/REM*: iterative engine, one bit per cycle, XLEN iterations; CALC->DONE after last iteration; out_valid rises exactly XLEN+1 cycles after accept.
REQ-022 DONE: out_valid=1, alu_result/zero_flag stable; DONE->IDLE on out_ready=1; held indefinitely while out_ready=0.
REQ-023 Divide by zero: DIV/DIVU quotient = all ones, REM/REMU = src_a; single-cycle path.
REQ-024 Signed overflow (src_a = most-negative, src_b = -1): DIV = src_a, REM = 0; single-cycle path.
REQ-025 Signed DIV/REM: quotient rounds toward zero, remainder takes sign of dividend.
REQ-026 No back-to-back accept in the same cycle out_valid drops: new request accepted earliest the cycle after DONE->IDLE (throughput ≤1 per 2 cycles).

Reset
REQ-027 rst asserted at any time SHALL immediately force state IDLE, out_valid=0, alu_result=0, zero_flag=0, iteration counter and engine registers 0; in-flight operation discarded.
REQ-028 in_ready SHALL read 1 while in reset and in the first cycle after deassertion.

Structure
REQ-029 Package alu_md_pkg SHALL hold the alu_op encoding constants, FSM state typedef and opcode-class helpers (is_muldiv, is_signed).
REQ-030 Single-cycle ops SHALL be in sub-module alu_comb (combinational, XLEN-parametrised); iterative engine and FSM stay in alu_md.

Verification
REQ-031 XLEN=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, zero_flag 0, out_valid 1 cycle after accept.
REQ-032 SRA src_a=0x80000000, src_b=0x00000024 (shamt 4) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same -> 0.
REQ-033 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000, MULHU same -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready 0 throughout.
REQ-034 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/-1 -> 0x80000000.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; in_valid ignored until release.
REQ-036 rst pulsed mid-CALC (cycle 10 of DIVU) -> out_valid 0, result 0 immediately; next request completes correctly; repeat at XLEN=64 for MULHU and DIVU (65-cycle latency).
